// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the largest supported requester count and the helper that sizes the
// round-robin pointer.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } arb_state_e;

  localparam int NREQ_MAX = 8;

  // Bits needed to hold a requester index 0..n-1 (at least one bit).
  function automatic int rr_idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches the request vector starting
// at ptr_i and wrapping modulo NREQ; returns the first requester found.
// Ports:
//   req_i  - request vector, one bit per requester
//   ptr_i  - index where the search starts (always < NREQ)
//   win_o  - one-hot winner, all zero when nothing requests
//   hit_o  - high when some requester won
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]             req_i,
  input  logic [rr_idx_w(NREQ)-1:0]   ptr_i,
  output logic [NREQ-1:0]             win_o,
  output logic                        hit_o
);

  localparam int IW = rr_idx_w(NREQ);

  logic [IW-1:0] idx;
  int            slot;

  always_comb begin
    win_o = '0;
    hit_o = 1'b0;
    idx   = '0;
    slot  = 0;
    for (int k = 0; k < NREQ; k++) begin
      slot = int'(ptr_i) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      idx = IW'(slot);
      if (!hit_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        hit_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Packet-locked round-robin arbiter sharing one uart_tx serializer between
// NREQ byte-stream requesters. An owner keeps the grant until the byte
// flagged last has been serialized; each byte is handed over with a single
// tx_start pulse and the next byte is accepted only after tx_done_tick.
// Optional feature macro: UART_ARB_TIMEOUT_EN enables an idle-owner
// watchdog that revokes the grant after TIMEOUT_CYCLES stalled cycles.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/data/last   - per-requester byte lanes (lane i = bits 8i+7:8i)
//   req_ready             - byte on lane i accepted when valid & ready
//   grant                 - one-hot current owner, zero when idle
//   tx_start, tx_din      - start pulse and registered byte to uart_tx
//   tx_done_tick          - frame-complete pulse from uart_tx
//   busy                  - arbiter not idle
//   timeout_tick          - watchdog revoked a grant (0 without the macro)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic              timeout_tick
);

  localparam int IW = rr_idx_w(NREQ);

  arb_state_e    state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          last_q, last_d;
  logic [7:0]    tx_din_q, tx_din_d;
  logic          tx_start_q, tx_start_d;

  logic [NREQ-1:0] pick_win;
  logic            pick_hit;

  logic [IW-1:0] owner_idx;
  logic [7:0]    owner_byte;
  logic          owner_valid;
  logic          owner_last;
  logic [IW-1:0] rr_next;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        tout_q, tout_d;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .win_o (pick_win),
    .hit_o (pick_hit)
  );

  // Owner lane selection; grant_q is one-hot so only one lane contributes.
  always_comb begin
    owner_idx  = '0;
    owner_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q[k]) begin
        owner_idx  = IW'(k);
        owner_byte = req_data[8*k +: 8];
      end
    end
    owner_valid = |(req_valid & grant_q);
    owner_last  = |(req_last & grant_q);
  end

  assign rr_next = (owner_idx == IW'(NREQ - 1)) ? '0 : owner_idx + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    last_d     = last_q;
    tx_din_d   = tx_din_q;
    tx_start_d = 1'b0;
    req_ready  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    tout_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d = pick_win;
          state_d = LOAD;
        end
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      LOAD: begin
        req_ready = grant_q;
        if (owner_valid) begin
          tx_din_d   = owner_byte;
          last_d     = owner_last;
          tx_start_d = 1'b1;
          state_d    = SEND;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_next;
          tout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      SEND: begin
        if (tx_done_tick) begin
          if (last_q) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_next;
          end else begin
            state_d = LOAD;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      last_q     <= 1'b0;
      tx_din_q   <= 8'h00;
      tx_start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      tout_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
      tx_din_q   <= tx_din_d;
      tx_start_q <= tx_start_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign busy     = (state_q != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_tick = tout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_tick       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NREQ = 4). Requesters are byte
// buffers driven each cycle; a behavioural uart_tx answers every tx_start
// with a tx_done_tick after a random delay. Expected packet order is
// computed from the round-robin rules at packet level.
// With UART_ARB_TIMEOUT_EN defined the watchdog scenario replaces the
// long back-pressure scenario.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            tx_start;
  logic [7:0]      tx_din;
  logic            tx_done_tick;
  logic            busy;
  logic            timeout_tick;

  uart_tx_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .timeout_tick (timeout_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // requester byte buffers: bit 8 = last flag
  logic [8:0] lbuf [N][256];
  int         lhead [N];
  int         ltail [N];
  logic [N-1:0] hs_prev;

  // uart model and observation logs
  bit   outstanding;
  int   done_cnt;
  bit   uart_auto;
  int   uart_max_delay;
  bit   inject_tick;
  int   cyc;
  int   proto_err;
  int   first_ready [N];
  int   obs_lane [$];
  logic [7:0] obs_byte [$];
  int   done_cyc [$];
  int   exp_lane [$];
  logic [7:0] exp_byte [$];

  function automatic int onehot_idx(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (g[i]) r = i;
    return r;
  endfunction

  function automatic bit lanes_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (lhead[i] < ltail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic push(input int lane, input logic [7:0] b, input logic last);
    lbuf[lane][ltail[lane]] = {last, b};
    ltail[lane]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (lhead[i] < ltail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = lbuf[i][lhead[i]][7:0];
        req_last[i]        = lbuf[i][lhead[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    hs_prev = req_valid & req_ready;
  endtask

  task automatic clear_logs();
    obs_lane.delete();
    obs_byte.delete();
    done_cyc.delete();
    proto_err = 0;
    for (int i = 0; i < N; i++) first_ready[i] = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (hs_prev[i]) lhead[i]++;
    for (int i = 0; i < N; i++) if (req_ready[i] && first_ready[i] < 0) first_ready[i] = cyc;
    if ((grant & (grant - 4'd1)) != 4'd0) proto_err++;
    tx_done_tick = 1'b0;
    if (outstanding && !tx_start && uart_auto) begin
      done_cnt--;
      if (done_cnt <= 0) begin
        tx_done_tick = 1'b1;
        outstanding  = 1'b0;
        done_cyc.push_back(cyc);
      end
    end
    if (inject_tick) begin
      tx_done_tick = 1'b1;
      inject_tick  = 1'b0;
    end
    if (tx_start) begin
      if (outstanding) proto_err++;
      outstanding = 1'b1;
      done_cnt    = 1 + $urandom_range(0, uart_max_delay);
      obs_lane.push_back(onehot_idx(grant));
      obs_byte.push_back(tx_din);
    end
    drive();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    tx_done_tick = 1'b0;
    req_valid    = '0;
    for (int i = 0; i < N; i++) begin
      lhead[i] = 0;
      ltail[i] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    reset       = 1'b0;
    outstanding = 1'b0;
    inject_tick = 1'b0;
    drive();
  endtask

  task automatic run_until_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      tick();
      if (lanes_empty() && !outstanding && !busy && !tx_start && !tx_done_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_mis++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_mis++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (tx_start !== 1'b0) begin n_mis++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    n_cmp++; if (tx_din !== 8'h00) begin n_mis++; $display("FAIL reset_tx_din got %h want 00", tx_din); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (timeout_tick !== 1'b0) begin n_mis++; $display("FAIL reset_timeout got %b want 0", timeout_tick); end
    reset = 1'b0;
    drive();
  endtask

  task automatic test_single_packet();
    bit ok;
    clear_logs();
    push(2, 8'hA5, 1'b0);
    push(2, 8'h3C, 1'b1);
    drive();
    tick();
    n_cmp++; if (grant !== 4'b0100) begin n_mis++; $display("FAIL single_grant got %b want 0100", grant); end
    n_cmp++; if (req_ready !== 4'b0100) begin n_mis++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    n_cmp++; if (tx_start !== 1'b1 || tx_din !== 8'hA5) begin n_mis++; $display("FAIL single_start1 got start=%b din=%h want 1/a5", tx_start, tx_din); end
    tick();
    n_cmp++; if (tx_start !== 1'b0 || grant !== 4'b0100) begin n_mis++; $display("FAIL single_pulse got start=%b grant=%b want 0/0100", tx_start, grant); end
    run_until_idle(300, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL single_done got timeout want idle"); end
    n_cmp++; if (obs_byte.size() != 2 || obs_byte[0] !== 8'hA5 || obs_byte[1] !== 8'h3C) begin
      n_mis++; $display("FAIL single_bytes got %0d bytes want a5,3c", obs_byte.size()); end
    n_cmp++; if (obs_lane.size() != 2 || obs_lane[0] != 2 || obs_lane[1] != 2) begin
      n_mis++; $display("FAIL single_lanes got %0d entries want lane 2 twice", obs_lane.size()); end
    n_cmp++; if (grant !== 4'b0000) begin n_mis++; $display("FAIL single_grant_end got %b want 0000", grant); end
  endtask

  task automatic test_fairness();
    bit ok;
    int exp_l [5];
    exp_l = '{0, 1, 2, 3, 0};
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);
    push(0, 8'h99, 1'b1);
    drive();
    run_until_idle(500, ok);
    n_cmp++; if (!ok || obs_lane.size() != 5) begin n_mis++; $display("FAIL fair_count got %0d want 5", obs_lane.size()); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (((k < obs_lane.size()) ? obs_lane[k] : -1) != exp_l[k]) begin
        n_mis++; $display("FAIL fair_order[%0d] got %0d want %0d", k, (k < obs_lane.size()) ? obs_lane[k] : -1, exp_l[k]);
      end
    end
  endtask

  task automatic test_packet_lock();
    bit ok;
    int m;
    do_reset();
    clear_logs();
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b1);
    push(1, 8'h44, 1'b1);
    drive();
    run_until_idle(500, ok);
    n_cmp++; if (!ok || done_cyc.size() != 4) begin n_mis++; $display("FAIL lock_done got %0d ticks want 4", done_cyc.size()); end
    m = (done_cyc.size() >= 3) ? done_cyc[2] : -100;
    n_cmp++; if (first_ready[1] != m + 2) begin n_mis++; $display("FAIL lock_ready1 got cycle %0d want %0d", first_ready[1], m + 2); end
    n_cmp++; if (obs_lane.size() != 4 || obs_lane[0] != 0 || obs_lane[2] != 0 || obs_lane[3] != 1) begin
      n_mis++; $display("FAIL lock_order got %0d entries want 0,0,0,1", obs_lane.size()); end
  endtask

  task automatic test_back_pressure();
    bit ok;
    int c;
    do_reset();
    clear_logs();
    push(3, 8'h5A, 1'b0);
    drive();
    c = 0;
    while (done_cyc.size() == 0 && c < 100) begin tick(); c++; end
    n_cmp++; if (done_cyc.size() != 1) begin n_mis++; $display("FAIL bp_first got %0d ticks want 1", done_cyc.size()); end
    for (int k = 0; k < 100; k++) begin
      if (k == 50) inject_tick = 1'b1;
      tick();
    end
    n_cmp++; if (req_ready !== 4'b1000 || busy !== 1'b1) begin
      n_mis++; $display("FAIL bp_hold got ready=%b busy=%b want 1000/1", req_ready, busy); end
    n_cmp++; if (obs_byte.size() != 1) begin n_mis++; $display("FAIL bp_nostart got %0d starts want 1", obs_byte.size()); end
    push(3, 8'hC3, 1'b1);
    drive();
    run_until_idle(300, ok);
    n_cmp++; if (!ok || obs_byte.size() != 2 || obs_byte[1] !== 8'hC3 || obs_lane[1] != 3) begin
      n_mis++; $display("FAIL bp_resume got %0d starts want 2 ending c3 on lane 3", obs_byte.size()); end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    int c;
    do_reset();
    clear_logs();
    push(2, 8'h22, 1'b1);
    drive();
    run_until_idle(300, ok);
    uart_auto = 1'b0;
    push(1, 8'h77, 1'b0);
    push(1, 8'h88, 1'b1);
    drive();
    c = 0;
    while (!outstanding && c < 20) begin tick(); c++; end
    tick();
    n_cmp++; if (busy !== 1'b1 || grant !== 4'b0010) begin n_mis++; $display("FAIL rst_pre got busy=%b grant=%b want 1/0010", busy, grant); end
    do_reset();
    n_cmp++; if ({grant, req_ready, tx_start, tx_din, busy, timeout_tick} !== 20'h0) begin
      n_mis++; $display("FAIL rst_mid got grant=%b ready=%b start=%b din=%h busy=%b tout=%b want all 0",
                        grant, req_ready, tx_start, tx_din, busy, timeout_tick); end
    uart_auto   = 1'b1;
    inject_tick = 1'b1;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000 || tx_start !== 1'b0) begin
      n_mis++; $display("FAIL rst_stray got busy=%b grant=%b start=%b want 0/0000/0", busy, grant, tx_start); end
    clear_logs();
    push(3, 8'h33, 1'b1);
    push(0, 8'h0F, 1'b1);
    drive();
    run_until_idle(300, ok);
    n_cmp++; if (!ok || obs_lane.size() != 2 || obs_lane[0] != 0 || obs_lane[1] != 3) begin
      n_mis++; $display("FAIL rst_ptr got %0d entries (first %0d) want 0 then 3", obs_lane.size(),
                        (obs_lane.size() > 0) ? obs_lane[0] : -1); end
  endtask

  task automatic test_random();
    bit ok;
    int mh [N];
    int p, ln, npk, len;
    bit found;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      clear_logs();
      uart_max_delay = $urandom_range(0, 6);
      for (int i = 0; i < N; i++) begin
        npk = $urandom_range(0, 3);
        for (int q = 0; q < npk; q++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push(i, 8'($urandom), (b == len - 1));
        end
      end
      exp_lane.delete();
      exp_byte.delete();
      for (int i = 0; i < N; i++) mh[i] = 0;
      p = 0;
      while (1) begin
        found = 1'b0;
        ln = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && mh[(p + k) % N] < ltail[(p + k) % N]) begin
            found = 1'b1;
            ln    = (p + k) % N;
          end
        end
        if (!found) break;
        do begin
          exp_lane.push_back(ln);
          exp_byte.push_back(lbuf[ln][mh[ln]][7:0]);
          mh[ln]++;
        end while (!lbuf[ln][mh[ln] - 1][8]);
        p = (ln + 1) % N;
      end
      drive();
      run_until_idle(5000, ok);
      n_cmp++; if (!ok || obs_byte.size() != exp_byte.size()) begin
        n_mis++; $display("FAIL rand%0d_count got %0d bytes want %0d", r, obs_byte.size(), exp_byte.size()); end
      for (int k = 0; k < exp_byte.size() && k < obs_byte.size(); k++) begin
        n_cmp++;
        if (obs_lane[k] != exp_lane[k] || obs_byte[k] !== exp_byte[k]) begin
          n_mis++; $display("FAIL rand%0d_item[%0d] got lane %0d byte %h want lane %0d byte %h",
                            r, k, obs_lane[k], obs_byte[k], exp_lane[k], exp_byte[k]);
        end
      end
      n_cmp++; if (proto_err != 0) begin n_mis++; $display("FAIL rand%0d_proto got %0d errors want 0", r, proto_err); end
    end
    uart_max_delay = 3;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int c, m;
    do_reset();
    clear_logs();
    push(1, 8'h42, 1'b0);
    drive();
    c = 0;
    while (done_cyc.size() == 0 && c < 100) begin tick(); c++; end
    m = (done_cyc.size() > 0) ? done_cyc[0] : -100;
    push(0, 8'h01, 1'b1);
    push(3, 8'h03, 1'b1);
    drive();
    c = 0;
    while (timeout_tick !== 1'b1 && c < 50) begin tick(); c++; end
    n_cmp++; if (timeout_tick !== 1'b1 || cyc != m + 11) begin
      n_mis++; $display("FAIL tout_when got tick=%b at cycle %0d want 1 at %0d", timeout_tick, cyc, m + 11); end
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_mis++; $display("FAIL tout_clear got grant=%b busy=%b want 0000/0", grant, busy); end
    tick();
    n_cmp++; if (timeout_tick !== 1'b0 || grant !== 4'b1000) begin
      n_mis++; $display("FAIL tout_next got tick=%b grant=%b want 0/1000", timeout_tick, grant); end
    run_until_idle(300, ok);
    n_cmp++; if (!ok || obs_lane.size() != 3 || obs_lane[1] != 3 || obs_lane[2] != 0) begin
      n_mis++; $display("FAIL tout_order got %0d entries want 1,3,0", obs_lane.size()); end
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    req_data       = '0;
    req_last       = '0;
    tx_done_tick   = 1'b0;
    hs_prev        = '0;
    outstanding    = 1'b0;
    done_cnt       = 0;
    uart_auto      = 1'b1;
    uart_max_delay = 3;
    inject_tick    = 1'b0;
    cyc            = 0;
    for (int i = 0; i < N; i++) begin
      lhead[i] = 0;
      ltail[i] = 0;
    end
    clear_logs();
    test_reset();
    test_single_packet();
    test_fairness();
    test_packet_lock();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_back_pressure();
`endif
    test_reset_mid_send();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
